// File: rtl/fsm_example_pkg.sv
// -----------------------------------------------------------------------------
// fsm_example_pkg
//   Shared definitions for the 3-state example FSM and its stimulus/monitor
//   blocks.
//   - state codes presented on the FSM's dout pins
//   - response error codes
//   - driver FSM states
//   - dout decode function
//   - target -> (a, b) drive pattern function
// -----------------------------------------------------------------------------
package fsm_example_pkg;

  // 3-bit codes the example FSM presents on dout for its three states.
  localparam logic [2:0] CODE_S0 = 3'b001;
  localparam logic [2:0] CODE_S1 = 3'b010;
  localparam logic [2:0] CODE_S2 = 3'b011;

  // Target value that names no state; a request for it is rejected up front.
  localparam logic [1:0] TGT_BAD = 2'd3;

  typedef enum logic [1:0] {
    ERR_OK         = 2'b00,
    ERR_TIMEOUT    = 2'b01,
    ERR_ILLEGAL    = 2'b10,
    ERR_BAD_TARGET = 2'b11
  } rsp_err_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CHECK = 2'd1,
    ST_DRIVE = 2'd2,
    ST_RESP  = 2'd3
  } drv_state_e;

  // Result of decoding dout. st is meaningful only when legal is set.
  typedef struct packed {
    logic       legal;
    logic [1:0] st;
  } decode_t;

  // Levels to hold on the FSM's a/b inputs.
  typedef struct packed {
    logic a;
    logic b;
  } drive_t;

  function automatic decode_t decode_dout(input logic [2:0] code);
    decode_t d;
    d = '{legal: 1'b1, st: 2'd0};
    case (code)
      CODE_S0: d.st = 2'd0;
      CODE_S1: d.st = 2'd1;
      CODE_S2: d.st = 2'd2;
      default: d = '{legal: 1'b0, st: 2'd0};
    endcase
    return d;
  endfunction

  // The pattern steers the FSM to the target from any source state and
  // keeps it there once it has arrived.
  function automatic drive_t drive_pattern(input logic [1:0] tgt);
    drive_t p;
    case (tgt)
      2'd0:    p = '{a: 1'b1, b: 1'b0};
      2'd1:    p = '{a: 1'b0, b: 1'b1};
      2'd2:    p = '{a: 1'b1, b: 1'b1};
      default: p = '{a: 1'b0, b: 1'b0};
    endcase
    return p;
  endfunction

endpackage

// File: rtl/fsm_example_driver.sv
// -----------------------------------------------------------------------------
// fsm_example_driver
//   Accepts a "go to state" request, drives the example FSM's a/b inputs and
//   watches its dout code until the target state is reached, an illegal code
//   appears, or TIMEOUT drive cycles have elapsed. Every request gets exactly
//   one response carrying a status, the decoded state and the cycles spent.
//
//   Parameters
//     TIMEOUT    max DRIVE cycles before giving up (must be >= 2)
//     CNT_W      width of the cycle counter and rsp_cycles
//
//   Ports
//     clk, rst_n       clock, synchronous active-low reset
//     req_vld/req_rdy  request handshake, req_st = target state (3 illegal)
//     rsp_vld/rsp_rdy  response handshake
//     rsp_err          00 OK, 01 TIMEOUT, 10 ILLEGAL_CODE, 11 BAD_TARGET
//     rsp_st           decoded state at completion (0 on illegal/bad target)
//     rsp_cycles       DRIVE cycles spent
//     fsm_a, fsm_b     drive the FSM's a/b inputs
//     fsm_dout         FSM state code
//
//   Every output comes straight from a flop; the output process computes the
//   next value of each output from the next state, so no input reaches an
//   output combinationally.
// -----------------------------------------------------------------------------
module fsm_example_driver
  import fsm_example_pkg::*;
#(
  parameter int TIMEOUT = 8,
  parameter int CNT_W   = $clog2(TIMEOUT + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_vld,
  output logic             req_rdy,
  input  logic [1:0]       req_st,
  output logic             rsp_vld,
  input  logic             rsp_rdy,
  output logic [1:0]       rsp_err,
  output logic [1:0]       rsp_st,
  output logic [CNT_W-1:0] rsp_cycles,
  output logic             fsm_a,
  output logic             fsm_b,
  input  logic [2:0]       fsm_dout
);

  // Counter value of the last permitted DRIVE cycle (counter+1 == TIMEOUT).
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  drv_state_e       state_q, state_d;
  logic [1:0]       tgt_q, tgt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cnt_inc;

  logic             req_rdy_q, req_rdy_d;
  logic             rsp_vld_q, rsp_vld_d;
  rsp_err_e         rsp_err_q, rsp_err_d;
  logic [1:0]       rsp_st_q, rsp_st_d;
  logic [CNT_W-1:0] rsp_cyc_q, rsp_cyc_d;
  drive_t           drv_q, drv_d;

  decode_t          dec;
  logic             accept;
  logic             match;
  logic             last_cyc;

  assign dec      = decode_dout(fsm_dout);
  // req_rdy is registered, so during the first cycle after reset release the
  // state is already IDLE while req_rdy is still 0; the handshake must use
  // the visible ready, not the state.
  assign accept   = (state_q == ST_IDLE) && req_rdy_q && req_vld;
  assign match    = dec.legal && (dec.st == tgt_q);
  assign last_cyc = (cnt_q == CNT_LAST);
  assign cnt_inc  = cnt_q + CNT_W'(1);

  // ---------------------------------------------------------------------------
  // State and output registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      tgt_q     <= 2'd0;
      cnt_q     <= '0;
      req_rdy_q <= 1'b0;
      rsp_vld_q <= 1'b0;
      rsp_err_q <= ERR_OK;
      rsp_st_q  <= 2'd0;
      rsp_cyc_q <= '0;
      drv_q     <= '{a: 1'b0, b: 1'b0};
    end else begin
      state_q   <= state_d;
      tgt_q     <= tgt_d;
      cnt_q     <= cnt_d;
      req_rdy_q <= req_rdy_d;
      rsp_vld_q <= rsp_vld_d;
      rsp_err_q <= rsp_err_d;
      rsp_st_q  <= rsp_st_d;
      rsp_cyc_q <= rsp_cyc_d;
      drv_q     <= drv_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every combinational output gets a default before the case so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) state_d = (req_st == TGT_BAD) ? ST_RESP : ST_CHECK;
      end
      ST_CHECK: begin
        state_d = (!dec.legal || match) ? ST_RESP : ST_DRIVE;
      end
      ST_DRIVE: begin
        if (match || !dec.legal || last_cyc) state_d = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_rdy) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output / datapath next values
  // ---------------------------------------------------------------------------
  always_comb begin
    tgt_d     = tgt_q;
    cnt_d     = cnt_q;
    rsp_err_d = rsp_err_q;
    rsp_st_d  = rsp_st_q;
    rsp_cyc_d = rsp_cyc_q;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          tgt_d = req_st;
          if (req_st == TGT_BAD) begin
            rsp_err_d = ERR_BAD_TARGET;
            rsp_st_d  = 2'd0;
            rsp_cyc_d = '0;
          end
        end
      end
      ST_CHECK: begin
        cnt_d = '0;
        if (!dec.legal) begin
          rsp_err_d = ERR_ILLEGAL;
          rsp_st_d  = 2'd0;
          rsp_cyc_d = '0;
        end else if (match) begin
          rsp_err_d = ERR_OK;
          rsp_st_d  = dec.st;
          rsp_cyc_d = '0;
        end
      end
      ST_DRIVE: begin
        cnt_d = cnt_inc;
        // A legal match ends the drive first; an illegal code beats timeout.
        if (match) begin
          rsp_err_d = ERR_OK;
          rsp_st_d  = dec.st;
          rsp_cyc_d = cnt_inc;
        end else if (!dec.legal) begin
          rsp_err_d = ERR_ILLEGAL;
          rsp_st_d  = 2'd0;
          rsp_cyc_d = cnt_inc;
        end else if (last_cyc) begin
          rsp_err_d = ERR_TIMEOUT;
          rsp_st_d  = dec.st;
          rsp_cyc_d = cnt_inc;
        end
      end
      default: ;  // RESP holds every response field
    endcase

    // Handshake flags and drive levels follow the state being entered, so
    // ready and valid are mutually exclusive by construction.
    req_rdy_d = (state_d == ST_IDLE);
    rsp_vld_d = (state_d == ST_RESP);
    drv_d     = (state_d == ST_DRIVE) ? drive_pattern(tgt_q)
                                      : '{a: 1'b0, b: 1'b0};
  end

  assign req_rdy    = req_rdy_q;
  assign rsp_vld    = rsp_vld_q;
  assign rsp_err    = rsp_err_q;
  assign rsp_st     = rsp_st_q;
  assign rsp_cycles = rsp_cyc_q;
  assign fsm_a      = drv_q.a;
  assign fsm_b      = drv_q.b;

endmodule

// File: tb/tb_fsm_example_driver.sv
// -----------------------------------------------------------------------------
// tb_fsm_example_driver
//   Directed bench for fsm_example_driver. A small behavioural stand-in for
//   the example FSM moves to the state selected by a/b on each clock edge
//   where a or b is high; an override can force any dout code instead.
//   Latencies are counted in clock edges after the accepting edge E, sampling
//   1 time unit after each rising edge.
// -----------------------------------------------------------------------------
module tb_fsm_example_driver;

  localparam int TIMEOUT = 8;
  localparam int CNT_W   = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             req_vld;
  logic             req_rdy;
  logic [1:0]       req_st;
  logic             rsp_vld;
  logic             rsp_rdy;
  logic [1:0]       rsp_err;
  logic [1:0]       rsp_st;
  logic [CNT_W-1:0] rsp_cycles;
  logic             fsm_a;
  logic             fsm_b;
  logic [2:0]       fsm_dout;

  logic [2:0]       m_code;
  logic             ovr;
  logic [2:0]       ovr_val;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fsm_example_driver #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_vld    (req_vld),
    .req_rdy    (req_rdy),
    .req_st     (req_st),
    .rsp_vld    (rsp_vld),
    .rsp_rdy    (rsp_rdy),
    .rsp_err    (rsp_err),
    .rsp_st     (rsp_st),
    .rsp_cycles (rsp_cycles),
    .fsm_a      (fsm_a),
    .fsm_b      (fsm_b),
    .fsm_dout   (fsm_dout)
  );

  // Stand-in example FSM: a/b select the next state, 00 holds.
  always @(posedge clk) begin
    if (!rst_n)                 m_code <= 3'b001;
    else if (fsm_a && !fsm_b)   m_code <= 3'b001;
    else if (!fsm_a && fsm_b)   m_code <= 3'b010;
    else if (fsm_a && fsm_b)    m_code <= 3'b011;
  end

  assign fsm_dout = ovr ? ovr_val : m_code;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    while (!req_rdy && n < 20) begin
      cyc();
      n++;
    end
    check({tag, "_rdy_wait"}, req_rdy, 1);
  endtask

  // Issue one request and run until rsp_vld (bounded). lat counts edges after
  // E; drv counts sampled cycles with a or b high; ab ORs the levels seen.
  // ill_at >= 0 forces dout to 000 once lat reaches that value.
  task automatic run_req(input string tag, input logic [1:0] st,
                         input int ill_at, output int lat, output int drv,
                         output logic [1:0] ab);
    wait_ready(tag);
    req_st  = st;
    req_vld = 1'b1;
    cyc();
    req_vld = 1'b0;
    lat = 0;
    drv = 0;
    ab  = 2'b00;
    while (!rsp_vld && lat < 40) begin
      if (fsm_a || fsm_b) drv++;
      ab = ab | {fsm_a, fsm_b};
      if (lat == ill_at) begin
        ovr     = 1'b1;
        ovr_val = 3'b000;
      end
      cyc();
      lat++;
    end
    check({tag, "_rsp_vld"}, rsp_vld, 1);
    check({tag, "_rdy_excl"}, req_rdy, 0);
    check({tag, "_ab_resp"}, {fsm_a, fsm_b}, 0);
  endtask

  task automatic expect_rsp(input string tag, input int lat, input int drv,
                            input logic [1:0] ab, input int e_lat,
                            input int e_drv, input logic [1:0] e_ab,
                            input logic [1:0] e_err, input logic [1:0] e_st,
                            input int e_cyc);
    check({tag, "_lat"}, lat, e_lat);
    check({tag, "_drv"}, drv, e_drv);
    check({tag, "_ab"}, ab, e_ab);
    check({tag, "_err"}, rsp_err, e_err);
    check({tag, "_st"}, rsp_st, e_st);
    check({tag, "_cyc"}, rsp_cycles, e_cyc);
  endtask

  // With rsp_rdy high the response lives exactly one cycle.
  task automatic consume(input string tag);
    cyc();
    check({tag, "_vld_drop"}, rsp_vld, 0);
    check({tag, "_rdy_back"}, req_rdy, 1);
  endtask

  initial begin
    int         lat, drv, n, hold_ok;
    logic [1:0] ab;

    rst_n   = 1'b0;
    req_vld = 1'b0;
    req_st  = 2'd0;
    rsp_rdy = 1'b1;
    ovr     = 1'b0;
    ovr_val = 3'b000;

    // Reset state
    repeat (3) cyc();
    check("rst_req_rdy", req_rdy, 0);
    check("rst_rsp_vld", rsp_vld, 0);
    check("rst_ab", {fsm_a, fsm_b}, 0);
    check("rst_err", rsp_err, 0);
    check("rst_st", rsp_st, 0);
    check("rst_cyc", rsp_cycles, 0);
    rst_n = 1'b1;
    cyc();
    check("rel_req_rdy", req_rdy, 1);

    // st0 -> st2: drive 11 for two cycles, response at edge E+3
    run_req("mv02", 2'd2, -1, lat, drv, ab);
    expect_rsp("mv02", lat, drv, ab, 3, 2, 2'b11, 2'b00, 2'd2, 2);
    consume("mv02");

    // st2 -> st1
    run_req("mv21", 2'd1, -1, lat, drv, ab);
    expect_rsp("mv21", lat, drv, ab, 3, 2, 2'b01, 2'b00, 2'd1, 2);
    consume("mv21");

    // Already in st1: no drive, response at edge E+1
    run_req("same1", 2'd1, -1, lat, drv, ab);
    expect_rsp("same1", lat, drv, ab, 1, 0, 2'b00, 2'b00, 2'd1, 0);
    consume("same1");

    // Bad target: straight from IDLE to RESP
    run_req("bad3", 2'd3, -1, lat, drv, ab);
    expect_rsp("bad3", lat, drv, ab, 0, 0, 2'b00, 2'b11, 2'd0, 0);
    consume("bad3");

    // dout stuck at 001, target 1: timeout after TIMEOUT drive cycles
    ovr     = 1'b1;
    ovr_val = 3'b001;
    run_req("tmo", 2'd1, -1, lat, drv, ab);
    expect_rsp("tmo", lat, drv, ab, TIMEOUT + 1, TIMEOUT, 2'b01, 2'b01,
               2'd0, TIMEOUT);
    consume("tmo");

    // Illegal code seen in CHECK
    ovr_val = 3'b000;
    run_req("illchk", 2'd2, -1, lat, drv, ab);
    expect_rsp("illchk", lat, drv, ab, 1, 0, 2'b00, 2'b10, 2'd0, 0);
    consume("illchk");
    ovr = 1'b0;

    // Illegal code appears in the first DRIVE cycle: exit on the next edge
    run_req("illdrv", 2'd2, 1, lat, drv, ab);
    expect_rsp("illdrv", lat, drv, ab, 2, 1, 2'b11, 2'b10, 2'd0, 1);
    consume("illdrv");
    ovr = 1'b0;

    // Backpressure with a queued request; dout wiggles are ignored in RESP
    rsp_rdy = 1'b0;
    run_req("bp", 2'd0, -1, lat, drv, ab);
    expect_rsp("bp", lat, drv, ab, 3, 2, 2'b10, 2'b00, 2'd0, 2);
    req_st  = 2'd1;
    req_vld = 1'b1;
    ovr     = 1'b1;
    ovr_val = 3'b000;
    hold_ok = 0;
    for (int i = 0; i < 5; i++) begin
      cyc();
      ovr_val = 3'(i + 4);
      if (rsp_vld && !req_rdy && rsp_err == 2'b00 && rsp_st == 2'd0 &&
          rsp_cycles == 4'd2 && !fsm_a && !fsm_b)
        hold_ok++;
    end
    check("bp_hold", hold_ok, 5);
    ovr     = 1'b0;
    rsp_rdy = 1'b1;
    cyc();
    check("bp_vld_drop", rsp_vld, 0);
    check("bp_rdy_back", req_rdy, 1);
    cyc();
    req_vld = 1'b0;
    check("bp_q_accept", req_rdy, 0);
    n = 0;
    while (!rsp_vld && n < 40) begin
      cyc();
      n++;
    end
    check("bp_q_lat", n, 3);
    check("bp_q_err", rsp_err, 0);
    check("bp_q_st", rsp_st, 1);
    check("bp_q_cyc", rsp_cycles, 2);
    consume("bp_q");

    // Reset in the middle of DRIVE
    wait_ready("rstmid");
    req_st  = 2'd0;
    req_vld = 1'b1;
    cyc();
    req_vld = 1'b0;
    cyc();
    check("rstmid_ab_pre", {fsm_a, fsm_b}, 2'b10);
    rst_n = 1'b0;
    cyc();
    check("rstmid_ab", {fsm_a, fsm_b}, 0);
    check("rstmid_vld", rsp_vld, 0);
    check("rstmid_rdy", req_rdy, 0);
    rst_n = 1'b1;
    cyc();
    check("rstmid_rdy_rel", req_rdy, 1);
    check("rstmid_vld_rel", rsp_vld, 0);
    check("rstmid_cyc_rel", rsp_cycles, 0);

    // Fresh request after reset; stand-in FSM is back in st0
    run_req("post", 2'd0, -1, lat, drv, ab);
    expect_rsp("post", lat, drv, ab, 1, 0, 2'b00, 2'b00, 2'd0, 0);
    consume("post");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
